// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared encodings for the 16-bit multicycle CPU control path:
//               opcodes, FSM state encoding, ALU control codes, datapath
//               select codes, ALU operation classes and opcode helpers.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

  // Opcodes, instr[15:12]
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_JAL  = 4'b1101;

  // Controller states; encodings 12-15 are unused and trap to FETCH
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // ALU control codes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_NAND  = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  // ALU operand-B select
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_TWO   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC select (10/11 reserved)
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  // Operation class handed from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;

  // R-type: opcodes 0000..0110, ALU function taken from op[2:0]
  function automatic logic is_rtype(input logic [3:0] op);
    return (op[3] == 1'b0) && (op[2:0] != 3'b111);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return !((op == 4'b1100) || (op == 4'b1110) || (op == 4'b1111));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_aludec.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_aludec
// Description : ALU decoder. Maps the operation class chosen by the control
//               FSM plus the opcode function bits to the 3-bit ALU control.
// Ports       : aluop      in  2  operation class (ADD / SUB / FUNCT)
//               funct      in  3  op[2:0]
//               alucontrol out 3  ALU control code
// Revision    : 1.0  initial release
// ============================================================================
module ctrl_aludec
  import cpu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    if (aluop == ALUOP_SUB) begin
      alucontrol = ALU_SUB;
    end else if (aluop == ALUOP_FUNCT) begin
      // R-type opcodes carry the ALU function in their low bits
      case (funct)
        3'b000:  alucontrol = ALU_ADD;
        3'b001:  alucontrol = ALU_SUB;
        3'b010:  alucontrol = ALU_AND;
        3'b011:  alucontrol = ALU_OR;
        3'b100:  alucontrol = ALU_XOR;
        3'b101:  alucontrol = ALU_NAND;
        3'b110:  alucontrol = ALU_SLT;
        default: alucontrol = ALU_PASSB;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Moore-style main control FSM for the 16-bit multicycle CPU.
//               Sequences fetch/decode/execute/memory/writeback and drives all
//               datapath selects and enables.
// Ports       : clk, reset (async, active-high)
//               op[3:0], zero, carry        from datapath
//               pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg,
//               regdst, alusrcb[1:0], pcsrc[1:0], alucontrol[2:0]
//               state[3:0] (debug), illegal (sticky undefined-opcode flag)
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] op,
  input  logic       zero,
  input  logic       carry,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       illegal
);

  state_t r_state;
  state_t w_next_state;
  logic   r_illegal;
  logic   w_set_illegal;

  logic   w_pcwrite;
  logic   w_branch_eq;
  logic   w_branch_ne;
  logic   w_irwrite;
  logic   w_regwrite;
  logic   w_memwrite;
  aluop_t w_aluop;

  // No control decision depends on carry yet; kept on the interface for
  // future flag-based branches.
  logic   unused_carry;
  assign unused_carry = carry;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state  = S_FETCH;
    w_set_illegal = 1'b0;
    w_pcwrite     = 1'b0;
    w_branch_eq   = 1'b0;
    w_branch_ne   = 1'b0;
    w_irwrite     = 1'b0;
    w_regwrite    = 1'b0;
    w_memwrite    = 1'b0;
    alusrca       = 1'b0;
    iord          = 1'b0;
    memtoreg      = 1'b0;
    regdst        = 1'b0;
    alusrcb       = SRCB_B;
    pcsrc         = PCSRC_ALU;
    w_aluop       = ALUOP_ADD;

    case (r_state)
      S_FETCH: begin
        w_irwrite    = 1'b1;
        alusrcb      = SRCB_TWO;
        w_pcwrite    = 1'b1;
        w_next_state = S_DECODE;
      end

      S_DECODE: begin
        // Speculative branch target: PC+2+(imm<<1) lands in ALU-out
        alusrcb = SRCB_IMMSH;
        if (is_rtype(op)) begin
          w_next_state = S_EXEC;
        end else begin
          case (op)
            OP_ADDI:         w_next_state = S_ADDIEX;
            OP_LW, OP_SW:    w_next_state = S_MEMADR;
            OP_BEQ, OP_BNE:  w_next_state = S_BRANCH;
            OP_JAL:          w_next_state = S_JUMP;
            default: begin
              w_next_state  = S_FETCH;
              w_set_illegal = 1'b1;
            end
          endcase
        end
      end

      S_MEMADR: begin
        alusrca      = 1'b1;
        alusrcb      = SRCB_IMM;
        w_next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        iord         = 1'b1;
        w_next_state = S_MEMWB;
      end

      S_MEMWB: begin
        memtoreg     = 1'b1;
        w_regwrite   = 1'b1;
        w_next_state = S_FETCH;
      end

      S_MEMWR: begin
        iord         = 1'b1;
        w_memwrite   = 1'b1;
        w_next_state = S_FETCH;
      end

      S_EXEC: begin
        alusrca      = 1'b1;
        alusrcb      = SRCB_B;
        w_aluop      = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end

      S_ALUWB: begin
        regdst       = 1'b1;
        w_regwrite   = 1'b1;
        w_next_state = S_FETCH;
      end

      S_ADDIEX: begin
        alusrca      = 1'b1;
        alusrcb      = SRCB_IMM;
        w_next_state = S_ADDIWB;
      end

      S_ADDIWB: begin
        w_regwrite   = 1'b1;
        w_next_state = S_FETCH;
      end

      S_BRANCH: begin
        alusrca      = 1'b1;
        alusrcb      = SRCB_B;
        w_aluop      = ALUOP_SUB;
        pcsrc        = PCSRC_ALUOUT;
        w_branch_eq  = (op == OP_BEQ);
        w_branch_ne  = (op == OP_BNE);
        w_next_state = S_FETCH;
      end

      S_JUMP: begin
        pcsrc        = PCSRC_ALUOUT;
        w_pcwrite    = 1'b1;
        w_next_state = S_FETCH;
      end

      default: begin
        // Unused encodings: recover to FETCH and flag the event
        w_next_state  = S_FETCH;
        w_set_illegal = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // ALU decoder
  // --------------------------------------------------------------------------
  ctrl_aludec u_aludec (
    .aluop      (w_aluop),
    .funct      (op[2:0]),
    .alucontrol (alucontrol)
  );

  // --------------------------------------------------------------------------
  // Architectural enables. Reset gates them directly so nothing is written
  // while reset is held, even though the reset state (FETCH) requests writes.
  // --------------------------------------------------------------------------
  assign pcen     = ~reset & (w_pcwrite | (w_branch_eq & zero) | (w_branch_ne & ~zero));
  assign irwrite  = ~reset & w_irwrite;
  assign regwrite = ~reset & w_regwrite;
  assign memwrite = ~reset & w_memwrite;

  assign state   = r_state;
  assign illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. A reference model
//               gives, per opcode, the sequence of states an instruction walks
//               through and the control word expected in each of them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] op;
  logic       zero;
  logic       carry;
  logic       pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       illegal;

  int checks   = 0;
  int failures = 0;
  bit model_illegal = 1'b0;

  int path[6];
  int plen;

  logic [14:0] ctl;
  assign ctl = {pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst,
                alusrcb, pcsrc, alucontrol};

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .carry      (carry),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .state      (state),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  // Step sequence of one instruction, by instruction class.
  task automatic model_path(input logic [3:0] o);
    case (o)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
        path[0] = 0; path[1] = 1; path[2] = 6; path[3] = 7; plen = 4;
      end
      4'd7:  begin path[0] = 0; path[1] = 1; path[2] = 8; path[3] = 9; plen = 4; end
      4'd8:  begin path[0] = 0; path[1] = 1; path[2] = 2; path[3] = 3; path[4] = 4; plen = 5; end
      4'd9:  begin path[0] = 0; path[1] = 1; path[2] = 2; path[3] = 5; plen = 4; end
      4'd10, 4'd11: begin path[0] = 0; path[1] = 1; path[2] = 10; plen = 3; end
      4'd13: begin path[0] = 0; path[1] = 1; path[2] = 11; plen = 3; end
      default: begin path[0] = 0; path[1] = 1; plen = 2; end
    endcase
  endtask

  function automatic bit model_legal(input logic [3:0] o);
    return !(o == 4'd12 || o == 4'd14 || o == 4'd15);
  endfunction

  // Control word for a state: {pcen,irwrite,regwrite,memwrite,alusrca,iord,
  // memtoreg,regdst,alusrcb,pcsrc,alucontrol}
  function automatic logic [14:0] model_ctl(input int s, input logic [3:0] o, input logic z);
    logic pe, ir, rw, mw, sa, io, mr, rd;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    pe = 0; ir = 0; rw = 0; mw = 0; sa = 0; io = 0; mr = 0; rd = 0;
    sb = 2'b00; ps = 2'b00; ac = 3'b000;
    case (s)
      0:  begin pe = 1; ir = 1; sb = 2'b01; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  io = 1;
      4:  begin mr = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin sa = 1; ac = o[2:0]; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; sb = 2'b10; end
      9:  rw = 1;
      10: begin sa = 1; ac = 3'b001; ps = 2'b01; pe = (o == 4'd10) ? z : ~z; end
      11: begin ps = 2'b01; pe = 1; end
      default: ;
    endcase
    return {pe, ir, rw, mw, sa, io, mr, rd, sb, ps, ac};
  endfunction

  // --------------------------------------------------------------------------
  // Scenario driver: walks one instruction (or its first maxsteps steps),
  // checking each step at the falling edge. zmode 0/1 = fixed zero, 2 = random.
  // --------------------------------------------------------------------------
  task automatic run_and_check(input logic [3:0] o, input int zmode, input int maxsteps);
    logic [14:0] exp_ctl;
    int n;
    model_path(o);
    n = (maxsteps < plen) ? maxsteps : plen;
    op = o;
    for (int k = 0; k < n; k++) begin
      zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      carry = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (state !== 4'(path[k])) begin
        failures++;
        $display("FAIL state op=%b step=%0d got=%0d exp=%0d", o, k, state, path[k]);
      end
      exp_ctl = model_ctl(path[k], o, zero);
      checks++;
      if (ctl !== exp_ctl) begin
        failures++;
        $display("FAIL ctl op=%b step=%0d state=%0d zero=%b got=%b exp=%b",
                 o, k, path[k], zero, ctl, exp_ctl);
      end
      checks++;
      if (illegal !== model_illegal) begin
        failures++;
        $display("FAIL illegal op=%b step=%0d got=%b exp=%b", o, k, illegal, model_illegal);
      end
      @(posedge clk);
      #1;
    end
    if (n == plen && !model_legal(o)) model_illegal = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; op = 4'd0; zero = 1'b0; carry = 1'b0;
    model_illegal = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (state !== 4'd0) begin
        failures++; $display("FAIL reset_state got=%0d exp=0", state);
      end
      checks++;
      if ({pcen, irwrite, regwrite, memwrite} !== 4'b0000) begin
        failures++; $display("FAIL reset_enables got=%b exp=0000", {pcen, irwrite, regwrite, memwrite});
      end
      checks++;
      if (illegal !== 1'b0) begin
        failures++; $display("FAIL reset_illegal got=%b exp=0", illegal);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({irwrite, pcen, alusrcb, state} !== {1'b1, 1'b1, 2'b01, 4'd0}) begin
      failures++;
      $display("FAIL reset_release_fetch got irwrite=%b pcen=%b alusrcb=%b state=%0d exp 1 1 01 0",
               irwrite, pcen, alusrcb, state);
    end
  endtask

  task automatic test_rtype();
    run_and_check(4'd1, 2, 99);            // SUB
    for (int i = 0; i < 7; i++) run_and_check(4'(i), 2, 99);
  endtask

  task automatic test_mem();
    run_and_check(4'd8, 2, 99);            // LW
    run_and_check(4'd9, 2, 99);            // SW
    run_and_check(4'd7, 2, 99);            // ADDI
  endtask

  task automatic test_branch();
    run_and_check(4'd10, 1, 99);           // BEQ taken
    run_and_check(4'd10, 0, 99);           // BEQ not taken
    run_and_check(4'd11, 1, 99);           // BNE not taken
    run_and_check(4'd11, 0, 99);           // BNE taken
    run_and_check(4'd13, 2, 99);           // JAL
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 40; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      if (!model_legal(r)) r = 4'($urandom_range(0, 11));
      run_and_check(r, 2, 99);
    end
  endtask

  task automatic test_illegal();
    run_and_check(4'd0, 2, 99);
    run_and_check(4'd14, 2, 99);           // sets the sticky flag
    run_and_check(4'd8, 2, 99);
    run_and_check(4'd12, 2, 99);
    run_and_check(4'd1, 2, 99);
    run_and_check(4'd15, 2, 99);
    run_and_check(4'd10, 2, 99);
    checks++;
    if (illegal !== 1'b1) begin
      failures++; $display("FAIL illegal_sticky got=%b exp=1", illegal);
    end
  endtask

  task automatic test_reset_mid_sw();
    run_and_check(4'd9, 2, 3);             // FETCH, DECODE, MEMADR
    @(negedge clk);
    checks++;
    if ({state, memwrite} !== {4'd5, 1'b1}) begin
      failures++; $display("FAIL sw_memwr got state=%0d memwrite=%b exp 5 1", state, memwrite);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({state, memwrite, pcen, irwrite, regwrite} !== {4'd0, 4'b0000}) begin
      failures++;
      $display("FAIL sw_abort got state=%0d memwrite=%b pcen=%b irwrite=%b regwrite=%b exp 0 0 0 0 0",
               state, memwrite, pcen, irwrite, regwrite);
    end
    checks++;
    if (illegal !== 1'b0) begin
      failures++; $display("FAIL sw_abort_illegal got=%b exp=0", illegal);
    end
    model_illegal = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    run_and_check(4'd9, 2, 99);
    run_and_check(4'd8, 2, 99);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_branch();
    test_back_to_back_random();
    test_illegal();
    test_reset_mid_sw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control unit for the 16-bit multicycle CPU datapath.
- A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath select/enable from the 4-bit opcode and the ALU zero/carry flags.
- Sits beside the datapath; memory sees the datapath address/writedata plus this block's memwrite.

Parameters:
- None. Encodings are fixed in the shared package.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high; forces state FETCH
- op  input  4  opcode, instr[15:12] from the instruction register
- zero  input  1  ALU zero flag, combinational from the current ALU result
- carry  input  1  ALU carry flag, same timing as zero
- pcen  output  1  PC register enable
- irwrite  output  1  instruction register enable
- regwrite  output  1  register file write request
- memwrite  output  1  memory write strobe
- alusrca  output  1  0=PC, 1=A register
- iord  output  1  address select: 0=PC, 1=ALU-out register
- memtoreg  output  1  writeback data: 0=ALU-out, 1=data register
- regdst  output  1  destination register: 0=instr[8:6], 1=instr[5:3]
- alusrcb  output  2  00=B, 01=constant 2, 10=signimm, 11=signimm<<1
- pcsrc  output  2  00=ALU result, 01=ALU-out register, 10/11 reserved (never driven)
- alucontrol  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NAND, 110 SLT, 111 PASSB
- state  output  4  current FSM state, debug/verification
- illegal  output  1  sticky flag: undefined opcode decoded; cleared only by reset

Behaviour:
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NAND, 0110 SLT (R-type); 0111 ADDI; 1000 LW; 1001 SW; 1010 BEQ; 1011 BNE; 1101 JAL. Opcodes 1100, 1110 and 1111 are illegal.
- pcen = pcwrite | (branch_eq & zero) | (branch_ne & ~zero). pcwrite, branch_eq and branch_ne are internal state decodes.
- Unlisted outputs in each state are 0. Default alucontrol is ADD.
- FETCH(0): iord=0, irwrite=1, alusrca=0, alusrcb=01, pcsrc=00, pcwrite=1. Next state DECODE.
- DECODE(1): alusrca=0, alusrcb=11, so ALU-out = PC+2+(imm<<1).
  - Next: R-type->EXEC; ADDI->ADDIEX; LW/SW->MEMADR; BEQ/BNE->BRANCH; JAL->JUMP; illegal->FETCH and set illegal.
- MEMADR(2): alusrca=1, alusrcb=10. LW->MEMRD, SW->MEMWR.
- MEMRD(3): iord=1. Next MEMWB.
- MEMWB(4): regdst=0, memtoreg=1, regwrite=1. Next FETCH.
- MEMWR(5): iord=1, memwrite=1. Next FETCH.
- EXEC(6): alusrca=1, alusrcb=00, alucontrol = op[2:0] via the ALU decoder. Next ALUWB.
- ALUWB(7): regdst=1, memtoreg=0, regwrite=1. Next FETCH.
- ADDIEX(8): alusrca=1, alusrcb=10, ADD. Next ADDIWB.
- ADDIWB(9): regdst=0, memtoreg=0, regwrite=1. Next FETCH.
- BRANCH(10): alusrca=1, alusrcb=00, SUB, pcsrc=01; branch_eq if op=1010, branch_ne if op=1011. Next FETCH.
- JUMP(11): pcsrc=01, pcwrite=1. Next FETCH. Return-address capture for JAL is a datapath function.
- Encodings 12-15 are unreachable; if entered, go to FETCH and set illegal.
- Latency in cycles: R-type/ADDI 4, LW 5, SW 4, BEQ/BNE/JAL 3.
- While reset is high: state=FETCH, illegal=0, and pcen, irwrite, regwrite and memwrite are all forced 0.
- Reset asserted mid-instruction aborts it. No partial write occurs after the reset edge.
- First FETCH after reset deasserts occurs on the first rising edge.
- Control outputs are purely combinational from state (plus op and zero for pcen and alucontrol). They carry no registered delay.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants
  - state enum (4-bit)
  - alucontrol codes
  - alusrcb/pcsrc select codes
- One sub-module, ctrl_aludec: maps state-class and op to alucontrol. It is reused by a future pipelined control unit.

Test Plan:
- Reset high for 3 cycles, then low: state=0, all enables 0 during reset; first edge gives irwrite=1, pcen=1, alusrcb=01.
- op=0001 (SUB): states 0,1,6,7,0. In EXEC, alucontrol=001, alusrca=1, alusrcb=00. In ALUWB, regwrite=1, regdst=1.
- op=1000 (LW): states 0,1,2,3,4,0. MEMRD has iord=1. MEMWB has memtoreg=1, regwrite=1, regdst=0. memwrite stays 0 throughout.
- op=1010 (BEQ): with zero=1 in BRANCH, pcen=1, pcsrc=01. Repeated with zero=0, pcen=0. op=1011 (BNE) shows the inverse.
- op=1110: DECODE goes to FETCH, and illegal rises and stays 1 across following instructions until reset.
- op=1001 (SW), reset asserted during MEMWR: memwrite drops to 0 immediately and state returns to 0 asynchronously.
